// File: rtl/matrix_loader.sv
// Collects two N x N operand matrices (A, then B) from a word stream, row-major,
// and holds them stable for a downstream multiplier until it acknowledges.
//
// state  | meaning
// LOAD_A | accepting words into operand A, slot = load_count
// LOAD_B | accepting words into operand B, slot = load_count
// HOLD   | both operands complete; input stalled until mat_ack
module matrix_loader #(
  parameter int N = 4,
  parameter int W = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [W-1:0]                 in_data,
  output logic [W*N*N:0]               matrix_A,
  output logic [W*N*N:0]               matrix_B,
  output logic                         mat_valid,
  input  logic                         mat_ack,
  output logic [$clog2(N*N+1)-1:0]     load_count
);

  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);
  localparam logic [CW-1:0] LAST = CW'(NN - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t       state;
  logic [W-1:0] mem_a [NN];
  logic [W-1:0] mem_b [NN];
  logic         transfer;

  assign in_ready = (state == LOAD_A || state == LOAD_B) && !rst;
  assign transfer = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= LOAD_A;
      load_count <= '0;
      mat_valid  <= 1'b0;
      for (int k = 0; k < NN; k++) begin
        mem_a[k] <= '0;
        mem_b[k] <= '0;
      end
    end else begin
      case (state)
        LOAD_A: begin
          if (transfer) begin
            for (int k = 0; k < NN; k++)
              if (load_count == CW'(k)) mem_a[k] <= in_data;
            if (load_count == LAST) begin
              state      <= LOAD_B;
              load_count <= '0;
            end else begin
              load_count <= load_count + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (transfer) begin
            for (int k = 0; k < NN; k++)
              if (load_count == CW'(k)) mem_b[k] <= in_data;
            if (load_count == LAST) begin
              state      <= HOLD;
              load_count <= '0;
              mat_valid  <= 1'b1;
            end else begin
              load_count <= load_count + 1'b1;
            end
          end
        end
        HOLD: begin
          // Buffers are left intact; the next load overwrites them slot by slot.
          if (mat_ack) begin
            state     <= LOAD_A;
            mat_valid <= 1'b0;
          end
        end
        default: begin
          state      <= LOAD_A;
          load_count <= '0;
          mat_valid  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    matrix_A = '0;
    matrix_B = '0;
    for (int k = 0; k < NN; k++) begin
      matrix_A[W*k +: W] = mem_a[k];
      matrix_B[W*k +: W] = mem_b[k];
    end
  end

endmodule

// File: tb/tb_matrix_loader.sv
// Randomized and directed bench for matrix_loader; a word-count reference model
// predicts handshake, counter and buffer contents every cycle.
module tb_matrix_loader;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int NN = N * N;
  localparam int CW = $clog2(NN + 1);

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [W-1:0]      in_data;
  logic [W*NN:0]     matrix_A;
  logic [W*NN:0]     matrix_B;
  logic              mat_valid;
  logic              mat_ack;
  logic [CW-1:0]     load_count;

  matrix_loader #(.N(N), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .matrix_A   (matrix_A),
    .matrix_B   (matrix_B),
    .mat_valid  (mat_valid),
    .mat_ack    (mat_ack),
    .load_count (load_count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference: number of words accepted in the current A+B load (0..2*NN),
  // plus the expected operand contents.
  int          accepted;
  logic [31:0] ea [NN];
  logic [31:0] eb [NN];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int exp_cnt;
    exp_cnt = (accepted < NN) ? accepted : (accepted < 2*NN) ? accepted - NN : 0;
    chk("in_ready", 64'(in_ready), 64'((accepted < 2*NN) && !rst));
    chk("mat_valid", 64'(mat_valid), 64'(accepted == 2*NN));
    chk("load_count", 64'(load_count), 64'(exp_cnt));
    for (int k = 0; k < NN; k++) begin
      chk($sformatf("A[%0d]", k), 64'(matrix_A[W*k +: W]), 64'(ea[k]));
      chk($sformatf("B[%0d]", k), 64'(matrix_B[W*k +: W]), 64'(eb[k]));
    end
    chk("A_msb", 64'(matrix_A[W*NN]), 64'd0);
    chk("B_msb", 64'(matrix_B[W*NN]), 64'd0);
  endtask

  task automatic cyc(input logic v, input logic [31:0] d, input logic a, input logic r);
    bit xfer;
    in_valid = v;
    in_data  = d;
    mat_ack  = a;
    rst      = r;
    xfer = v && (accepted < 2*NN) && !r;
    @(posedge clk);
    #1;
    if (r) begin
      accepted = 0;
      for (int k = 0; k < NN; k++) begin
        ea[k] = '0;
        eb[k] = '0;
      end
    end else if (xfer) begin
      if (accepted < NN) ea[accepted] = d;
      else               eb[accepted - NN] = d;
      accepted++;
    end else if (accepted == 2*NN && a) begin
      accepted = 0;
    end
    check_all();
  endtask

  task automatic load_seq(input int base, input bit gaps);
    for (int i = 0; i < 2*NN; i++) begin
      if (gaps) cyc(1'b0, $urandom, 1'b0, 1'b0);
      cyc(1'b1, 32'(base + i), 1'b0, 1'b0);
    end
  endtask

  initial begin
    accepted = 0;
    for (int k = 0; k < NN; k++) begin
      ea[k] = '0;
      eb[k] = '0;
    end
    in_valid = 1'b0;
    in_data  = '0;
    mat_ack  = 1'b0;
    rst      = 1'b1;

    repeat (3) cyc(1'b0, 32'd0, 1'b0, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0);

    // Continuous load of words 1..32
    load_seq(1, 1'b0);
    chk("seq_valid", 64'(mat_valid), 64'd1);
    chk("seq_A0", 64'(matrix_A[31:0]), 64'd1);
    chk("seq_A15", 64'(matrix_A[511:480]), 64'd16);
    chk("seq_B0", 64'(matrix_B[31:0]), 64'd17);
    chk("seq_B15", 64'(matrix_B[511:480]), 64'd32);

    // HOLD ignores input traffic, then ack releases it
    repeat (5) cyc(1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    chk("hold_A0", 64'(matrix_A[31:0]), 64'd1);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);
    chk("ack_ready", 64'(in_ready), 64'd1);
    chk("ack_valid", 64'(mat_valid), 64'd0);

    // Same sequence with a bubble before every word
    load_seq(1, 1'b1);
    chk("gap_B15", 64'(matrix_B[511:480]), 64'd32);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Ack while loading has no effect
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'(200 + i), 1'b1, 1'b0);
    chk("ackload_cnt", 64'(load_count), 64'd5);

    // Reset mid-load, then reset colliding with a transfer
    for (int i = 5; i < 10; i++) cyc(1'b1, 32'(200 + i), 1'b0, 1'b0);
    cyc(1'b1, 32'h55, 1'b0, 1'b1);
    chk("rst_cnt", 64'(load_count), 64'd0);
    chk("rst_A0", 64'(matrix_A[31:0]), 64'd0);
    cyc(1'b1, 32'h66, 1'b0, 1'b1);
    load_seq(1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Second back-to-back load
    load_seq(101, 1'b0);
    chk("b2b_A0", 64'(matrix_A[31:0]), 64'd101);
    chk("b2b_B15", 64'(matrix_B[511:480]), 64'd132);
    cyc(1'b0, 32'd0, 1'b1, 1'b0);

    // Random traffic with occasional acks and resets
    for (int i = 0; i < 800; i++)
      cyc($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 3) == 0,
          $urandom_range(0, 99) == 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 SHALL have parameter N, default 4, meaning matrix dimension (N x N elements per operand).
REQ-002 SHALL have parameter W, default 32, meaning element width in bits; the only supported value is 32.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset: synchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1 bit, upstream word valid.
REQ-006 SHALL have port in_ready, output, 1 bit, loader can accept a word this cycle.
REQ-007 SHALL have port in_data, input, 32 bits, element word, row-major, A first then B.
REQ-008 SHALL have port matrix_A, output, 32*N*N+1 bits, flat operand A; element (r,c) at bits [32k+31:32k], k=r*N+c.
REQ-009 SHALL have port matrix_B, output, 32*N*N+1 bits, flat operand B, same packing as matrix_A.
REQ-010 SHALL have port mat_valid, output, 1 bit, both operands complete and stable.
REQ-011 SHALL have port mat_ack, input, 1 bit, downstream multiplier has consumed the operands.
REQ-012 SHALL have port load_count, output, ceil(log2(N*N+1)) bits, words accepted into the current operand.

Function
REQ-013 SHALL implement FSM states LOAD_A, LOAD_B, HOLD.
REQ-014 SHALL assert in_ready combinationally = (state is LOAD_A or LOAD_B) and not rst.
REQ-015 SHALL define transfer = in_valid and in_ready; words are accepted only on transfer.
REQ-016 On transfer in LOAD_A, SHALL write in_data to matrix_A slot k=load_count and increment load_count.
REQ-017 On transfer in LOAD_B, SHALL write in_data to matrix_B slot k=load_count and increment load_count.
REQ-018 On transfer with load_count = N*N-1 in LOAD_A, SHALL go to LOAD_B and clear load_count to 0.
REQ-019 On transfer with load_count = N*N-1 in LOAD_B, SHALL go to HOLD, clear load_count, and set mat_valid = 1 on the next cycle (latency 1 cycle from last word).
REQ-020 SHALL hold matrix_A and matrix_B constant while in HOLD.
REQ-021 Bit 32*N*N of matrix_A and matrix_B SHALL always be 0.
REQ-022 In HOLD, in_valid SHALL be ignored (in_ready = 0, no write, no count change).
REQ-023 In HOLD with mat_ack = 1, SHALL go to LOAD_A and clear mat_valid on the next cycle; in_ready rises in that same cycle.
REQ-024 mat_ack while not in HOLD SHALL be ignored.
REQ-025 After mat_ack, operand buffers SHALL retain old contents until overwritten slot by slot.
REQ-026 Gaps (in_valid low) SHALL stall loading indefinitely with no state or count change.
REQ-027 load_count SHALL never exceed N*N-1.

Reset
REQ-028 While rst = 1 at a clock edge, SHALL set state LOAD_A, load_count 0, mat_valid 0, matrix_A 0, matrix_B 0.
REQ-029 rst SHALL take priority over transfer and mat_ack in the same cycle.
REQ-030 Reset mid-load SHALL discard all partially loaded words; loading restarts at A slot 0.

Verification
REQ-031 Sequence of words 1..32 with continuous valid (N=4) -> mat_valid = 1 the cycle after word 32; matrix_A[31:0]=1, matrix_A[511:480]=16, matrix_B[31:0]=17, matrix_B[511:480]=32, bit 512 = 0.
REQ-032 Same sequence with in_valid low on every other cycle -> identical final buffers; load_count advances only on transfer cycles.
REQ-033 In HOLD, drive in_valid=1 with in_data=0xDEADBEEF for 5 cycles -> in_ready=0, buffers unchanged; then mat_ack=1 for one cycle -> mat_valid=0 and in_ready=1 the next cycle.
REQ-034 rst pulsed after 10 accepted words -> load_count=0, state LOAD_A, matrix_A all 0; next 32 words load correctly from A slot 0.
REQ-035 mat_ack=1 during LOAD_A -> no effect; rst and transfer asserted in the same cycle -> word not stored, load_count 0.
REQ-036 Two back-to-back loads with ack between (second set 101..132) -> second mat_valid shows matrix_A[31:0]=101 and matrix_B[511:480]=132.
